goalkeeper_controller: RTL and testbench
========================================

GOALKEEPER_CONTROLLER -- requirements
Module: goalkeeper_controller

Interface
REQ-001 SHALL have parameter X_MIN, default 230, left goal-post pixel limit of keeper x.
REQ-002 SHALL have parameter X_MAX, default 410, right goal-post pixel limit of keeper x.
REQ-003 SHALL have parameter STEP, default 4, pixels moved per frame_tick.
REQ-004 SHALL have parameter SHIFT, default 1, left-shift applied to the random byte.
REQ-005 SHALL have parameter HOLD_FRAMES, default 30, frames held at target before returning.
REQ-006 clk  input  1  system clock; reset, synchronous, active-high; clock clk.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 frame_tick  input  1  one-cycle pulse per video frame.
REQ-009 kick  input  1  one-cycle pulse, ball kicked by player.
REQ-010 rnd_value  input  32  current value from the random number source, bits [7:0] used.
REQ-011 rnd_req  output  1  enable to the random number source; rising-edge triggered downstream.
REQ-012 keeper_x  output  10  keeper horizontal pixel position.
REQ-013 target_x  output  10  latched dive target.
REQ-014 diving  output  1  high in MOVE and HOLD.
REQ-015 dive_done  output  1  one-cycle pulse on entry to HOLD.

Function
REQ-016 SHALL implement FSM states IDLE, REQ, WAIT, LATCH, MOVE, HOLD, RETURN.
REQ-017 IDLE->REQ on kick; any kick outside IDLE SHALL be ignored; kick and frame_tick in the same IDLE cycle: kick wins, the frame is not counted.
REQ-018 REQ: rnd_req=1 for exactly one cycle; then WAIT for one cycle with rnd_req=0 (source updates on the edge ending REQ).
REQ-019 LATCH: target_x = X_MIN + (rnd_value[7:0] << SHIFT), computed in 11 bits, clamped to X_MAX; next state MOVE.
REQ-020 Kick-to-target_x-valid latency SHALL be 3 cycles (REQ, WAIT, LATCH).
REQ-021 MOVE: on each frame_tick, keeper_x moves toward target_x by min(STEP, |target_x-keeper_x|); no motion without frame_tick.
REQ-022 When keeper_x == target_x in MOVE (including at LATCH exit), go to HOLD next cycle and pulse dive_done once.
REQ-023 HOLD: count frame_ticks; on the HOLD_FRAMES-th tick, go to RETURN.
REQ-024 RETURN: move toward X_CENTER = (X_MIN+X_MAX)/2 by the same step rule; on arrival, go to IDLE.
REQ-025 keeper_x SHALL never leave [X_MIN, X_MAX]; no underflow or overflow on subtraction.

Reset
REQ-026 On reset, mid-operation or not: state=IDLE, keeper_x=X_CENTER, target_x=X_CENTER, rnd_req=0, diving=0, dive_done=0, hold counter=0.
REQ-027 Reset SHALL have priority over kick and frame_tick in the same cycle.

Structure
REQ-028 State encoding, screen width (640) and the position width (10) SHALL reside in shared package tabajara_pkg.
REQ-029 The step-toward-target arithmetic SHALL be one sub-module keeper_stepper (cur, tgt, step -> next), used by MOVE and RETURN.

Verification
REQ-030 Reset, kick, rnd_value=0x2D -> rnd_req pulses 1 cycle, target_x=320 after 3 cycles, immediate HOLD, dive_done pulse, keeper_x stays 320.
REQ-031 rnd_value=0x51 -> target_x=392; 18 frame_ticks to arrive; 30 ticks held; 18 ticks returning to 320; back to IDLE.
REQ-032 rnd_value=0xFF -> target_x clamped to 410; keeper_x stops at 410, never exceeds it.
REQ-033 Kick during MOVE or HOLD -> no rnd_req, target unchanged; kick with frame_tick in IDLE -> dive starts, hold count unaffected.
REQ-034 Reset asserted in MOVE at keeper_x=352 -> next cycle keeper_x=320, state IDLE, diving=0.

Source files
------------

// File: rtl/tabajara_pkg.sv
// -----------------------------------------------------------------------------
// tabajara_pkg
// Shared definitions for the goalkeeper logic: screen geometry, the width of
// pixel positions, the keeper FSM state encoding and a small clamp helper.
// -----------------------------------------------------------------------------
package tabajara_pkg;

  localparam int SCREEN_W = 640;
  localparam int POS_W    = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_LATCH,
    ST_MOVE,
    ST_HOLD,
    ST_RETURN
  } gk_state_t;

  // Clamp a one-bit-wider sum down to an upper pixel limit.
  function automatic logic [POS_W-1:0] clamp_hi(input logic [POS_W:0]   v,
                                                 input logic [POS_W-1:0] hi);
    logic [POS_W-1:0] r;
    if (v > {1'b0, hi}) r = hi;
    else                r = v[POS_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/keeper_stepper.sv
// -----------------------------------------------------------------------------
// keeper_stepper
// Purely combinational one-step mover: advances cur toward tgt by at most
// step pixels, never overshooting. The difference is always taken as
// larger-minus-smaller, so neither direction can wrap.
// Ports:
//   cur  - current position
//   tgt  - position being approached
//   step - maximum pixels per move
//   next - position after one move
// -----------------------------------------------------------------------------
module keeper_stepper
  import tabajara_pkg::*;
(
  input  logic [POS_W-1:0] cur,
  input  logic [POS_W-1:0] tgt,
  input  logic [POS_W-1:0] step,
  output logic [POS_W-1:0] next
);

  logic [POS_W-1:0] diff;
  logic [POS_W-1:0] amt;

  always_comb begin
    diff = '0;
    amt  = '0;
    next = cur;
    if (cur < tgt) begin
      diff = tgt - cur;
      amt  = (diff < step) ? diff : step;
      next = cur + amt;
    end else if (cur > tgt) begin
      diff = cur - tgt;
      amt  = (diff < step) ? diff : step;
      next = cur - amt;
    end
  end

endmodule

// File: rtl/goalkeeper_controller.sv
// -----------------------------------------------------------------------------
// goalkeeper_controller
// Drives the keeper sprite: on a kick it requests a random byte, turns it into
// a dive target inside the goal, walks the keeper there one step per frame,
// holds for a number of frames, then walks back to the goal centre.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   frame_tick  - one-cycle pulse per video frame (paces all motion)
//   kick        - one-cycle pulse, only honoured while idle
//   rnd_value   - random source output, bits [7:0] used
//   rnd_req     - one-cycle enable to the random source
//   keeper_x    - keeper horizontal pixel position
//   target_x    - latched dive target
//   diving      - high while moving to / holding at the target
//   dive_done   - one-cycle pulse on arrival at the target
// -----------------------------------------------------------------------------
module goalkeeper_controller
  import tabajara_pkg::*;
#(
  parameter int X_MIN       = 230,
  parameter int X_MAX       = 410,
  parameter int STEP        = 4,
  parameter int SHIFT       = 1,
  parameter int HOLD_FRAMES = 30
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic             kick,
  input  logic [31:0]      rnd_value,
  output logic             rnd_req,
  output logic [POS_W-1:0] keeper_x,
  output logic [POS_W-1:0] target_x,
  output logic             diving,
  output logic             dive_done
);

  localparam logic [POS_W-1:0] X_MIN_P    = POS_W'(X_MIN);
  localparam logic [POS_W-1:0] X_MAX_P    = POS_W'(X_MAX);
  localparam logic [POS_W-1:0] X_CENTER   = POS_W'((X_MIN + X_MAX) / 2);
  localparam logic [POS_W-1:0] STEP_P     = POS_W'(STEP);
  localparam int               HC_W       = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [HC_W-1:0]  HOLD_LAST  = HC_W'(HOLD_FRAMES - 1);

  gk_state_t        state_q, state_d;
  logic [POS_W-1:0] keeper_x_q, keeper_x_d;
  logic [POS_W-1:0] target_x_q, target_x_d;
  logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic             dive_done_q, dive_done_d;

  logic [POS_W:0]   raw_tgt;
  logic [POS_W-1:0] lat_tgt;
  logic [POS_W-1:0] step_tgt;
  logic [POS_W-1:0] step_next;
  logic [23:0]      unused_rnd_bits;

  assign unused_rnd_bits = rnd_value[31:8];

  // Target is formed one bit wider than a position so the sum of the base
  // and the shifted byte cannot wrap before it is clamped to the right post.
  always_comb begin
    raw_tgt = {1'b0, X_MIN_P} + ((POS_W+1)'(rnd_value[7:0]) << SHIFT);
    lat_tgt = clamp_hi(raw_tgt, X_MAX_P);
  end

  // One stepper serves both the dive and the return walk.
  assign step_tgt = (state_q == ST_RETURN) ? X_CENTER : target_x_q;

  keeper_stepper u_stepper (
    .cur  (keeper_x_q),
    .tgt  (step_tgt),
    .step (STEP_P),
    .next (step_next)
  );

  always_comb begin
    state_d     = state_q;
    keeper_x_d  = keeper_x_q;
    target_x_d  = target_x_q;
    hold_cnt_d  = hold_cnt_q;
    dive_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (kick) state_d = ST_REQ;
      end
      ST_REQ:   state_d = ST_WAIT;
      // Source output settles on the edge ending REQ; sample it one cycle later.
      ST_WAIT:  state_d = ST_LATCH;
      ST_LATCH: begin
        target_x_d = lat_tgt;
        state_d    = ST_MOVE;
      end
      ST_MOVE: begin
        if (keeper_x_q == target_x_q) begin
          state_d     = ST_HOLD;
          dive_done_d = 1'b1;
          hold_cnt_d  = '0;
        end else if (frame_tick) begin
          keeper_x_d = step_next;
        end
      end
      ST_HOLD: begin
        if (frame_tick) begin
          if (hold_cnt_q == HOLD_LAST) begin
            hold_cnt_d = '0;
            state_d    = ST_RETURN;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
      end
      ST_RETURN: begin
        if (keeper_x_q == X_CENTER) state_d = ST_IDLE;
        else if (frame_tick)        keeper_x_d = step_next;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      keeper_x_q  <= X_CENTER;
      target_x_q  <= X_CENTER;
      hold_cnt_q  <= '0;
      dive_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      keeper_x_q  <= keeper_x_d;
      target_x_q  <= target_x_d;
      hold_cnt_q  <= hold_cnt_d;
      dive_done_q <= dive_done_d;
    end
  end

  assign rnd_req   = (state_q == ST_REQ);
  assign diving    = (state_q == ST_MOVE) || (state_q == ST_HOLD);
  assign dive_done = dive_done_q;
  assign keeper_x  = keeper_x_q;
  assign target_x  = target_x_q;

  // X_MIN_P documents the left post; the target never falls below it because
  // the random offset is non-negative.
  logic unused_min;
  assign unused_min = ^X_MIN_P;

endmodule

// File: tb/tb_goalkeeper_controller.sv
// -----------------------------------------------------------------------------
// tb_goalkeeper_controller
// Directed bench with a scoreboard: stimulus pushes the expected event stream
// (random-request pulses, arrival pulses, every keeper position change) and a
// monitor on the falling clock edge pops and compares as the DUT produces them.
// -----------------------------------------------------------------------------
module tb_goalkeeper_controller;

  localparam logic [1:0] EV_REQ  = 2'd0;
  localparam logic [1:0] EV_DONE = 2'd1;
  localparam logic [1:0] EV_POS  = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [19:0] val;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        kick = 1'b0;
  logic [31:0] rnd_value = 32'd0;
  logic        rnd_req;
  logic [9:0]  keeper_x;
  logic [9:0]  target_x;
  logic        diving;
  logic        dive_done;

  int          n_vec = 0;
  int          n_bad = 0;
  ev_t         exp_q[$];
  logic        mon_en = 1'b0;
  logic [9:0]  prev_x = 10'd320;
  int          req_w = 0;
  logic        req_seen = 1'b0;
  logic [7:0]  next_rnd = 8'h00;

  goalkeeper_controller dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .kick       (kick),
    .rnd_value  (rnd_value),
    .rnd_req    (rnd_req),
    .keeper_x   (keeper_x),
    .target_x   (target_x),
    .diving     (diving),
    .dive_done  (dive_done)
  );

  always #5 clk = ~clk;

  // Random source model: presents a new value on the edge that ends the request.
  always @(negedge clk) req_seen <= rnd_req;
  always @(posedge clk) if (req_seen) rnd_value <= {24'd0, next_rnd};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_ev(input logic [1:0] kind, input logic [19:0] val);
    exp_q.push_back('{kind: kind, val: val});
  endtask

  task automatic observe(input logic [1:0] kind, input logic [19:0] val);
    ev_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got kind %0d value %0d, expected no event", kind, val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== kind || e.val !== val) begin
        n_bad++;
        $display("FAIL event_stream: got kind %0d value %0d, expected kind %0d value %0d",
                 kind, val, e.kind, e.val);
      end
    end
  endtask

  // Monitor: REQ events carry the pulse width, DONE carries {target_x, keeper_x}.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rnd_req) req_w++;
      else if (req_w != 0) begin
        observe(EV_REQ, 20'(req_w));
        req_w = 0;
      end
      if (dive_done) observe(EV_DONE, {target_x, keeper_x});
      if (keeper_x !== prev_x) begin
        observe(EV_POS, {10'd0, keeper_x});
        prev_x = keeper_x;
      end
    end
  end

  task automatic step(input logic k, input logic f);
    kick = k;
    frame_tick = f;
    @(posedge clk);
    #1;
    kick = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1);
  endtask

  // Kick, then run REQ/WAIT/LATCH; target is checked right after the third edge.
  task automatic launch(input logic [7:0] rv, input logic also_tick, input logic [9:0] exp_tgt,
                        input string name);
    next_rnd = rv;
    step(1'b1, also_tick);
    check({name, "_rnd_req_high"}, rnd_req, 1'b1);
    step(1'b0, 1'b0);
    check({name, "_rnd_req_low"}, rnd_req, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check({name, "_target_3cyc"}, target_x, exp_tgt);
    check({name, "_diving_move"}, diving, 1'b1);
  endtask

  initial begin
    // Reset state
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    reset = 1'b0;
    check("reset_keeper_x", keeper_x, 10'd320);
    check("reset_target_x", target_x, 10'd320);
    check("reset_rnd_req", rnd_req, 1'b0);
    check("reset_diving", diving, 1'b0);
    check("reset_dive_done", dive_done, 1'b0);
    mon_en = 1'b1;

    // 0x2D: target equals centre, immediate hold, keeper never moves
    push_ev(EV_REQ, 20'd1);
    push_ev(EV_DONE, {10'd320, 10'd320});
    launch(8'h2D, 1'b0, 10'd320, "c2d");
    step(1'b0, 1'b0);
    check("c2d_dive_done", dive_done, 1'b1);
    check("c2d_hold_diving", diving, 1'b1);
    ticks(29);
    check("c2d_hold_29", diving, 1'b1);
    ticks(1);
    check("c2d_hold_30", diving, 1'b0);
    step(1'b0, 1'b0);

    // 0x51: 392, paced moves with idle gaps, kicks in MOVE and HOLD ignored
    push_ev(EV_REQ, 20'd1);
    for (int i = 1; i <= 18; i++) push_ev(EV_POS, 20'(320 + 4 * i));
    push_ev(EV_DONE, {10'd392, 10'd392});
    for (int i = 1; i <= 18; i++) push_ev(EV_POS, 20'(392 - 4 * i));
    launch(8'h51, 1'b1, 10'd392, "c51");
    step(1'b1, 1'b0);
    check("c51_kick_move_tgt", target_x, 10'd392);
    for (int i = 0; i < 18; i++) begin
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
    end
    check("c51_arrived", keeper_x, 10'd392);
    step(1'b1, 1'b0);
    check("c51_kick_hold_tgt", target_x, 10'd392);
    ticks(29);
    check("c51_hold_29", diving, 1'b1);
    ticks(1);
    check("c51_hold_30", diving, 1'b0);
    ticks(18);
    check("c51_returned", keeper_x, 10'd320);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);

    // 0xFF: clamped to 410, extra tick at the post must not push past it
    push_ev(EV_REQ, 20'd1);
    for (int i = 1; i <= 22; i++) push_ev(EV_POS, 20'(320 + 4 * i));
    push_ev(EV_POS, 20'd410);
    push_ev(EV_DONE, {10'd410, 10'd410});
    for (int i = 1; i <= 22; i++) push_ev(EV_POS, 20'(410 - 4 * i));
    push_ev(EV_POS, 20'd320);
    launch(8'hFF, 1'b0, 10'd410, "cff");
    ticks(23);
    check("cff_at_post", keeper_x, 10'd410);
    ticks(1);
    check("cff_no_overshoot", keeper_x, 10'd410);
    ticks(30);
    ticks(23);
    check("cff_returned", keeper_x, 10'd320);
    step(1'b0, 1'b0);

    // Reset mid-MOVE at 352, together with kick and frame_tick
    push_ev(EV_REQ, 20'd1);
    for (int i = 1; i <= 8; i++) push_ev(EV_POS, 20'(320 + 4 * i));
    push_ev(EV_POS, 20'd320);
    launch(8'h51, 1'b0, 10'd392, "rst");
    ticks(8);
    check("rst_pre_keeper", keeper_x, 10'd352);
    reset = 1'b1;
    step(1'b1, 1'b1);
    reset = 1'b0;
    check("rst_keeper_x", keeper_x, 10'd320);
    check("rst_target_x", target_x, 10'd320);
    check("rst_diving", diving, 1'b0);
    check("rst_rnd_req", rnd_req, 1'b0);
    step(1'b0, 1'b1);
    check("rst_stays_idle", rnd_req, 1'b0);

    // Reset part-way through HOLD; the next dive still holds a full count
    push_ev(EV_REQ, 20'd1);
    push_ev(EV_DONE, {10'd320, 10'd320});
    launch(8'h2D, 1'b0, 10'd320, "rh1");
    step(1'b0, 1'b0);
    ticks(10);
    reset = 1'b1;
    step(1'b0, 1'b0);
    reset = 1'b0;
    check("rh_diving", diving, 1'b0);
    push_ev(EV_REQ, 20'd1);
    push_ev(EV_DONE, {10'd320, 10'd320});
    launch(8'h2D, 1'b0, 10'd320, "rh2");
    step(1'b0, 1'b0);
    ticks(29);
    check("rh_hold_29", diving, 1'b1);
    ticks(1);
    check("rh_hold_30", diving, 1'b0);
    step(1'b0, 1'b0);

    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
